// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline control unit for the 5-stage RISC-V core.
//
// This block drives the stall, flush and halt controls of the pipeline
// registers. It handles the following cases:
//   - load-use hazards,
//   - taken branches,
//   - multicycle EX operations (div/rem), timed by an internal countdown,
//   - a full-pipeline halt on ebreak/ecall retiring in WB, held until resume.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   id_rs1/id_rs2, id_uses_rs1/2    ID source registers and their use flags
//   ex_rd, ex_mem_read              EX destination register, EX is a load
//   ex_branch_taken                 EX resolved a taken branch/jump
//   ex_mc_start                     EX holds a multicycle op
//   wb_halt_req, resume             halt request from WB, external restart
//   stall_if, stall_idex            stall PC+IF/ID, stall ID/EX
//   flush_ifid/idex/exmem           bubble insertion per register
//   halt                            freeze every pipeline register
//   state                           RUN=0, MC_WAIT=1, HALTED=2
//   stall_count                     saturating count of stall_if cycles
module hazard_ctrl #(
    parameter int MC_LATENCY = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_branch_taken,
    input  logic                 ex_mc_start,
    input  logic                 wb_halt_req,
    input  logic                 resume,
    output logic                 stall_if,
    output logic                 stall_idex,
    output logic                 flush_ifid,
    output logic                 flush_idex,
    output logic                 flush_exmem,
    output logic                 halt,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int MCW = $clog2(MC_LATENCY) + 1;
    localparam logic [MCW-1:0] MC_INIT = MCW'(MC_LATENCY - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [MCW-1:0]       r_mc_cnt;
    logic [MCW-1:0]       w_mc_cnt_next;
    logic [CNT_WIDTH-1:0] r_stall_count;
    logic                 w_load_use;
    logic                 w_stall_if, w_stall_idex;
    logic                 w_flush_ifid, w_flush_idex, w_flush_exmem;

    assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        w_stall_if    = 1'b0;
        w_stall_idex  = 1'b0;
        w_flush_ifid  = 1'b0;
        w_flush_idex  = 1'b0;
        w_flush_exmem = 1'b0;
        w_next        = r_state;
        w_mc_cnt_next = r_mc_cnt;
        case (r_state)
            RUN: begin
                if (wb_halt_req) begin
                    w_flush_ifid  = 1'b1;
                    w_flush_idex  = 1'b1;
                    w_flush_exmem = 1'b1;
                    w_next        = HALTED;
                end else if (ex_mc_start) begin
                    // Hold the op in EX; the start cycle counts as the
                    // first of the MC_LATENCY stall cycles.
                    w_stall_if    = 1'b1;
                    w_stall_idex  = 1'b1;
                    w_flush_exmem = 1'b1;
                    w_mc_cnt_next = MC_INIT;
                    w_next        = MC_WAIT;
                end else if (ex_branch_taken) begin
                    // Also covers a branch that coincides with load-use:
                    // the ID instruction is wrong-path, so it is squashed
                    // instead of stalled.
                    w_flush_ifid  = 1'b1;
                    w_flush_idex  = 1'b1;
                end else if (w_load_use) begin
                    w_stall_if    = 1'b1;
                    w_flush_idex  = 1'b1;
                end
            end
            MC_WAIT: begin
                if (wb_halt_req) begin
                    // An older ebreak wins; the in-flight div is dropped.
                    w_flush_ifid  = 1'b1;
                    w_flush_idex  = 1'b1;
                    w_flush_exmem = 1'b1;
                    w_mc_cnt_next = '0;
                    w_next        = HALTED;
                end else if (r_mc_cnt != '0) begin
                    w_stall_if    = 1'b1;
                    w_stall_idex  = 1'b1;
                    w_flush_exmem = 1'b1;
                    w_mc_cnt_next = r_mc_cnt - 1'b1;
                end else begin
                    // Release cycle: all controls low so the result moves on.
                    w_next        = RUN;
                end
            end
            HALTED: begin
                if (resume) w_next = RUN;
            end
            default: w_next = RUN;
        endcase

        if (reset) begin
            w_stall_if    = 1'b0;
            w_stall_idex  = 1'b0;
            w_flush_ifid  = 1'b0;
            w_flush_idex  = 1'b0;
            w_flush_exmem = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_mc_cnt      <= '0;
            r_stall_count <= '0;
        end else begin
            r_state  <= w_next;
            r_mc_cnt <= w_mc_cnt_next;
            if (w_stall_if && (r_stall_count != {CNT_WIDTH{1'b1}}))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_if    = w_stall_if;
    assign stall_idex  = w_stall_idex;
    assign flush_ifid  = w_flush_ifid;
    assign flush_idex  = w_flush_idex;
    assign flush_exmem = w_flush_exmem;
    assign halt        = (r_state == HALTED) && !reset;
    assign state       = r_state;
    assign stall_count = r_stall_count;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit for the 5-stage RISC-V core. It generates the per-stage stall, flush and halt controls consumed by the `flopr` pipeline registers (PC, IF/ID, ID/EX, EX/MEM). It resolves load-use hazards and taken branches, and sequences multicycle EX operations (div/rem) with an internal countdown. It also freezes the whole pipeline on an ebreak/ecall retiring in WB until `resume`.

## Interface
- `MC_LATENCY`, default 32: number of stall cycles a multicycle EX operation needs; legal range ≥ 1.
- `CNT_WIDTH`, default 16: width of the stall performance counter.

- `clk`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  ID instruction actually reads that source.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_mem_read`  in  1  EX instruction is a load.
- `ex_branch_taken`  in  1  EX resolved a taken branch or jump.
- `ex_mc_start`  in  1  EX holds a multicycle op (div/divu/rem/remu).
- `wb_halt_req`  in  1  ebreak/ecall retiring in WB.
- `resume`  in  1  external restart from HALTED.
- `stall_if`  out  1  to `stall` of PC and IF/ID registers.
- `stall_idex`  out  1  to `stall` of ID/EX register.
- `flush_ifid`, `flush_idex`, `flush_exmem`  out  1 each  bubble insertion: drives the target register's `reset`, OR'd with global reset.
- `halt`  out  1  to `halt` of every pipeline register.
- `state`  out  2  RUN=0, MC_WAIT=1, HALTED=2; 3 unused.
- `stall_count`  out  CNT_WIDTH  cycles with `stall_if`=1 since reset.

## Operation
- FSM states: RUN, MC_WAIT, HALTED. Registered `mc_cnt`, ceil(log2(MC_LATENCY))+1 bits.
- Control outputs are combinational from state and inputs. `halt` is decoded from state only (state==HALTED).
- Priority in RUN, highest first: wb_halt_req > ex_mc_start > ex_branch_taken > load-use. Only the winning action's outputs are asserted; all others are 0.
- Load-use hazard: `ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd))`.
- RUN, wb_halt_req: `flush_ifid`=`flush_idex`=`flush_exmem`=1; next state HALTED.
- RUN, ex_mc_start: `stall_if`=`stall_idex`=`flush_exmem`=1; `mc_cnt`←MC_LATENCY-1; next state MC_WAIT.
- RUN, ex_branch_taken: `flush_ifid`=`flush_idex`=1 for one cycle; state unchanged.
- RUN, load-use: `stall_if`=1 and `flush_idex`=1 for one cycle.
- MC_WAIT, wb_halt_req (older ebreak reaching WB): all three flushes=1; `mc_cnt`←0; next state HALTED. The aborted div is discarded.
- MC_WAIT, mc_cnt≠0: `stall_if`=`stall_idex`=`flush_exmem`=1; `mc_cnt` decrements.
- MC_WAIT, mc_cnt==0: release cycle; all outputs 0, so the result advances to MEM; next state RUN.
- In MC_WAIT, `ex_mc_start`, `ex_branch_taken` and load-use are ignored. `ex_mc_start` stays high during the hold and must not retrigger.
- HALTED: `halt`=1 and all other controls 0. `resume`=1 moves to RUN next cycle. `wb_halt_req` is ignored. `resume` is ignored in RUN and MC_WAIT.
- `stall_count`: +1 on each cycle with `stall_if`=1; saturates at all-ones; never wraps.

## Timing
- Reset: state=RUN, `mc_cnt`=0, `stall_count`=0. While `reset`=1 all control outputs are forced to 0 and `halt`=0.
- Reset mid-MC_WAIT or mid-HALTED: the next cycle is RUN with no residual stall.
- Multicycle op: the start cycle plus MC_LATENCY-1 wait cycles give MC_LATENCY cycles with stall asserted. The release cycle follows, so the op occupies EX for MC_LATENCY+1 cycles.
- MC_LATENCY=1: start cycle stalls, the next cycle is release.
- Load-use costs exactly 1 bubble. A taken branch costs 2 flushed slots.
- Halt: the request cycle flushes. `halt`=1 from the following cycle. `resume` seen in cycle t gives `halt`=0 in cycle t+1.
- Branch and load-use in the same cycle: flush only, no stall, because the ID instruction is wrong-path.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → one cycle `stall_if`=1, `flush_idex`=1, `stall_count`=1. Repeat with ex_rd=0 → no stall.
- Multicycle, MC_LATENCY=4: ex_mc_start held high → `stall_if` high for 4 cycles, then one release cycle with all 0, then state=RUN; no retrigger.
- Branch+load-use in the same cycle → `flush_ifid`=`flush_idex`=1, `stall_if`=0.
- Halt: wb_halt_req pulse → three flushes, then `halt`=1 and state=2 until resume. A resume pulse 10 cycles later gives `halt`=0 one cycle after. A second wb_halt_req while HALTED has no effect.
- Halt during MC_WAIT (2nd wait cycle) → flushes, state HALTED, `mc_cnt`=0. After resume, no stale stall.
- Reset asserted mid-MC_WAIT and mid-HALTED → all outputs 0, state=0, `stall_count`=0 next cycle. Saturation: CNT_WIDTH=4 with 20 load-use stalls → `stall_count`=15.
